reg_bus_arbiter: RTL
====================

Name: reg_bus_arbiter

Overview:
- Two-requester arbiter and sequencer in front of one synchronous register bank, e.g. a block-RAM holding-register file.
- Requester A is the Modbus register path; requester B is a local master such as a sequencer or soft core.
- Serialises each transaction: grant, issue target strobe, wait fixed read latency, return ack and data. Fair round-robin between requesters.

Parameters:
- ADDR_W, 16, register address width
- DATA_W, 16, register data width
- RD_LAT, 1, target read latency in cycles from oTgtRdEn to valid iTgtDataRd; legal range 0..3

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- iReqA  in  1  A request; held high until ack
- iWeA  in  1  A: 1 = write, 0 = read
- iAddrA  in  ADDR_W  A address
- iDataWrA  in  DATA_W  A write data
- oAckA  out  1  A completion, one-cycle pulse
- oDataRdA  out  DATA_W  A read data; valid while oAckA=1, held until next A read ack
- iReqB / iWeB / iAddrB / iDataWrB / oAckB / oDataRdB  same as A, for requester B
- oTgtAddr  out  ADDR_W  target address
- oTgtDataWr  out  DATA_W  target write data
- oTgtWrEn  out  1  target write strobe, one cycle
- oTgtRdEn  out  1  target read strobe, one cycle
- iTgtDataRd  in  DATA_W  target read data
- oBusy  out  1  high in every state except IDLE
- oGrantB  out  1  owner of the current or last transaction: 0 = A, 1 = B

Behaviour:
- Reset values: all outputs 0. FSM in IDLE. Last-grant pointer = B, so A wins the first tie. Reset asserted mid-transaction aborts immediately: strobes and acks drop asynchronously, no ack is issued for the aborted transaction.
- FSM states: IDLE -> ISSUE -> WAIT (reads only, RD_LAT cycles; skipped when RD_LAT = 0) -> ACK -> IDLE.
- IDLE: if any request is high, select a winner.
  - Only one request high: that requester wins.
  - Both high: the requester not granted last wins.
  - Latch the winner's we, addr and wdata into internal registers; update the pointer; go to ISSUE.
- ISSUE: drive oTgtAddr and oTgtDataWr from the latched values. Assert oTgtWrEn (write) or oTgtRdEn (read) for exactly this cycle. Write -> ACK. Read -> WAIT, or -> ACK when RD_LAT = 0.
- WAIT: count RD_LAT cycles. On the last one, iTgtDataRd is sampled into the owner's oDataRd register.
  - RD_LAT = 0: data is sampled at the end of the ISSUE cycle instead.
- ACK: assert oAckA or oAckB for exactly one cycle, then IDLE.
- Latency, measured from cycle 0 = IDLE cycle with the request high:
  - write: strobe in cycle 1, ack in cycle 2
  - read: strobe in cycle 1, ack in cycle 2 + RD_LAT
- Throughput: one transaction per 3 + RD_LAT cycles (write counts as RD_LAT = 0). A request still high in the cycle after its ack starts a new arbitration.
- Latched address and data are used for the whole transaction; requester input changes after grant have no effect.
- Protocol violation: requester drops req before ack. The transaction still completes and the ack still pulses; no error is flagged.
- oTgtAddr and oTgtDataWr hold their last values outside ISSUE. Never more than one strobe high at a time. oAckA and oAckB are never high together.
- Write data passes through unmodified; no width conversion.

Optional Feature:
- Macro: REG_BUS_ARB_PRIO_A_EN
- Defined: fixed priority, A always wins a tie. Last-grant pointer is still maintained and oGrantB is still driven, but the pointer is ignored for selection.
- Undefined: round-robin as specified above.

Test Plan:
- Reset release, then A writes addr 0x0002, data 0x1234 -> oTgtWrEn high in cycle 1 with oTgtAddr=0x0002 and oTgtDataWr=0x1234; oAckA in cycle 2; oBusy high for cycles 1-2.
- RD_LAT=1; B reads 0x0004 while the target returns 0xBEEF -> oTgtRdEn in cycle 1, oAckB in cycle 3, oDataRdB=0xBEEF; oDataRdA unchanged.
- A and B both request continuously for 6 transactions -> grants A,B,A,B,A,B. With REG_BUS_ARB_PRIO_A_EN defined -> A,A,A,A,A,A (B starves).
- A's address changes from 0x0002 to 0x0003 in the cycle after grant -> target still sees 0x0002; exactly one ack.
- rst pulled low during WAIT of a read -> all outputs 0 immediately, no ack after release, next request from A is granted first.
- RD_LAT=0 and RD_LAT=3 builds; read 0x0000 -> ack at cycle 2 and cycle 5 respectively, data correct.

Source files
------------

// File: rtl/reg_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_bus_arbiter_if
// Description : Bundles the two requester ports and the register-bank target
//               port of reg_bus_arbiter. The 'slave' modport is the arbiter's
//               view. The 'master' modport is the view of whatever drives the
//               requests and models the target.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_bus_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  // Requester A (Modbus register path)
  logic              iReqA;
  logic              iWeA;
  logic [ADDR_W-1:0] iAddrA;
  logic [DATA_W-1:0] iDataWrA;
  logic              oAckA;
  logic [DATA_W-1:0] oDataRdA;
  // Requester B (local master)
  logic              iReqB;
  logic              iWeB;
  logic [ADDR_W-1:0] iAddrB;
  logic [DATA_W-1:0] iDataWrB;
  logic              oAckB;
  logic [DATA_W-1:0] oDataRdB;
  // Register bank target
  logic [ADDR_W-1:0] oTgtAddr;
  logic [DATA_W-1:0] oTgtDataWr;
  logic              oTgtWrEn;
  logic              oTgtRdEn;
  logic [DATA_W-1:0] iTgtDataRd;
  // Status
  logic              oBusy;
  logic              oGrantB;

  modport slave (
    input  iReqA, iWeA, iAddrA, iDataWrA,
    input  iReqB, iWeB, iAddrB, iDataWrB,
    input  iTgtDataRd,
    output oAckA, oDataRdA, oAckB, oDataRdB,
    output oTgtAddr, oTgtDataWr, oTgtWrEn, oTgtRdEn,
    output oBusy, oGrantB
  );

  modport master (
    output iReqA, iWeA, iAddrA, iDataWrA,
    output iReqB, iWeB, iAddrB, iDataWrB,
    output iTgtDataRd,
    input  oAckA, oDataRdA, oAckB, oDataRdB,
    input  oTgtAddr, oTgtDataWr, oTgtWrEn, oTgtRdEn,
    input  oBusy, oGrantB
  );
endinterface
`default_nettype wire

// File: rtl/reg_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : reg_bus_arbiter
// Description : Two-requester arbiter/sequencer for one synchronous register
//               bank. Each transaction runs IDLE -> ISSUE -> (WAIT) -> ACK.
//               Ties are resolved round-robin by default. Defining
//               REG_BUS_ARB_PRIO_A_EN gives requester A fixed priority on
//               ties.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_bus_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  reg_bus_arbiter_if.slave   bus
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_ISSUE = 2'd1;
  localparam logic [1:0] c_WAIT  = 2'd2;
  localparam logic [1:0] c_ACK   = 2'd3;
  // Counter value on the final WAIT cycle; unused when RD_LAT is 0.
  localparam logic [1:0] c_WAIT_LAST = (RD_LAT == 0) ? 2'd0 : 2'(RD_LAT - 1);

  logic [1:0]        r_state;
  logic [1:0]        w_nextState;
  logic              r_lastB;
  logic              r_grantB;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [1:0]        r_waitCnt;
  logic [DATA_W-1:0] r_dataRdA;
  logic [DATA_W-1:0] r_dataRdB;
  logic              w_anyReq;
  logic              w_pickB;
  logic              w_waitDone;
  logic              w_capture;

  assign w_anyReq   = bus.iReqA | bus.iReqB;
`ifdef REG_BUS_ARB_PRIO_A_EN
  assign w_pickB    = bus.iReqB & ~bus.iReqA;
`else
  // On a tie the requester that was not granted last wins.
  assign w_pickB    = bus.iReqB & (~bus.iReqA | ~r_lastB);
`endif
  assign w_waitDone = (r_waitCnt == c_WAIT_LAST);
  // With zero latency the bank answers combinationally during the strobe.
  assign w_capture  = (RD_LAT == 0) ? ((r_state == c_ISSUE) && !r_we)
                                    : ((r_state == c_WAIT) && w_waitDone);

  // Target address/data come straight from the latched request, so they hold
  // their last values between transactions.
  assign bus.oTgtAddr   = r_addr;
  assign bus.oTgtDataWr = r_wdata;
  assign bus.oDataRdA   = r_dataRdA;
  assign bus.oDataRdB   = r_dataRdB;
  assign bus.oGrantB    = r_grantB;

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= c_IDLE;
    else      r_state <= w_nextState;
  end

  // Next-state sequencing.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      c_IDLE:  if (w_anyReq) w_nextState = c_ISSUE;
      c_ISSUE: w_nextState = (r_we || (RD_LAT == 0)) ? c_ACK : c_WAIT;
      c_WAIT:  if (w_waitDone) w_nextState = c_ACK;
      c_ACK:   w_nextState = c_IDLE;
      default: w_nextState = c_IDLE;
    endcase
  end

  // Strobes, acks and busy decoded from the current state.
  always_comb begin
    bus.oTgtWrEn = 1'b0;
    bus.oTgtRdEn = 1'b0;
    bus.oAckA    = 1'b0;
    bus.oAckB    = 1'b0;
    bus.oBusy    = (r_state != c_IDLE);
    case (r_state)
      c_ISSUE: begin
        bus.oTgtWrEn = r_we;
        bus.oTgtRdEn = ~r_we;
      end
      c_ACK: begin
        bus.oAckA = ~r_grantB;
        bus.oAckB = r_grantB;
      end
      default: ;
    endcase
  end

  // Latch the winner's request and update the last-grant pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lastB  <= 1'b1;
      r_grantB <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else if ((r_state == c_IDLE) && w_anyReq) begin
      r_lastB  <= w_pickB;
      r_grantB <= w_pickB;
      r_we     <= w_pickB ? bus.iWeB     : bus.iWeA;
      r_addr   <= w_pickB ? bus.iAddrB   : bus.iAddrA;
      r_wdata  <= w_pickB ? bus.iDataWrB : bus.iDataWrA;
    end
  end

  // Count read-latency cycles while in WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   r_waitCnt <= 2'd0;
    else if (r_state == c_WAIT) r_waitCnt <= r_waitCnt + 2'd1;
    else                        r_waitCnt <= 2'd0;
  end

  // Capture read data into the owner's holding register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dataRdA <= '0;
      r_dataRdB <= '0;
    end else if (w_capture) begin
      if (r_grantB) r_dataRdB <= bus.iTgtDataRd;
      else          r_dataRdA <= bus.iTgtDataRd;
    end
  end

endmodule
`default_nettype wire
